// File: rtl/wbm_arbiter_if.sv
// ---------------------------------------------------------------------------
// wbm_arbiter_if
//   Bundle of every bus-side signal of the two-master / one-slave pipelined
//   Wishbone arbiter. Signal names carry the arbiter's own direction suffix
//   (_i = into the arbiter, _o = out of the arbiter).
//
//   m0_* : port 0 (instruction fetch) master link
//   m1_* : port 1 (LSU) master link
//   s_*  : shared slave link
//
//   Modports:
//     slave  - the arbiter's view (it terminates the master links and
//              drives the shared slave link)
//     master - the environment's view (masters and slave model)
// ---------------------------------------------------------------------------
interface wbm_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 16
);
  // Port 0 (fetch)
  logic              m0_cyc_i;
  logic              m0_stb_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [DATA_W-1:0] m0_dat_i;
  logic              m0_gnt_o;
  logic              m0_stall_o;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_dat_o;
  // Port 1 (LSU)
  logic              m1_cyc_i;
  logic              m1_stb_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [DATA_W-1:0] m1_dat_i;
  logic              m1_gnt_o;
  logic              m1_stall_o;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_dat_o;
  // Slave
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [DATA_W-1:0] s_dat_o;
  logic              s_ack_i;
  logic [DATA_W-1:0] s_dat_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_gnt_o, m0_stall_o, m0_ack_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_gnt_o, m1_stall_o, m1_ack_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_gnt_o, m0_stall_o, m0_ack_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_gnt_o, m1_stall_o, m1_ack_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wbm_arbiter.sv
// ---------------------------------------------------------------------------
// wbm_arbiter
//   Shares one pipelined Wishbone slave between port 0 (fetch) and port 1
//   (LSU). A master owns the bus for a whole burst; ownership is released
//   only once that master has dropped cyc and every outstanding beat has
//   been acknowledged. Ties from IDLE go to the port that did not own the
//   bus last (port 0 wins the first tie after reset).
//
//   Handshake: a beat transfers on a cycle where the master holds stb high
//   and its stall_o is low; a stalled master keeps the same beat on its
//   inputs. Each transferred beat is owed exactly one s_ack_i, returned in
//   order; acks arriving with nothing outstanding are dropped.
//
//   Ports:
//     clk_i     clock, all state on rising edge
//     reset_ni  asynchronous active-low reset
//     bus       wbm_arbiter_if.slave (master links m0/m1 + slave link s)
//     state_o   debug: FSM state (0 IDLE, 1 OWN0, 2 OWN1)
//     count_o   debug: outstanding-beat count
// ---------------------------------------------------------------------------
module wbm_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  wbm_arbiter_if.slave     bus,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;

  logic own0, own1;
  logic own_cyc, own_stb;
  logic cnt_full, cnt_nz;
  logic fwd_stb, ack_ok, release_own;

  always_comb begin
    own0     = (state_q == OWN0);
    own1     = (state_q == OWN1);
    cnt_full = (count_q == CNT_MAX);
    cnt_nz   = (count_q != '0);
    // Acks with nothing outstanding are spurious and never reach a master.
    ack_ok   = bus.s_ack_i & cnt_nz;

    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (own0) begin
      own_cyc = bus.m0_cyc_i;
      own_stb = bus.m0_stb_i;
    end else if (own1) begin
      own_cyc = bus.m1_cyc_i;
      own_stb = bus.m1_stb_i;
    end
    fwd_stb = own_stb & ~cnt_full;

    // Slave link
    bus.s_cyc_o = own0 | own1;
    bus.s_stb_o = fwd_stb;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    if (own0) begin
      bus.s_we_o  = bus.m0_we_i;
      bus.s_adr_o = bus.m0_adr_i;
      bus.s_dat_o = bus.m0_dat_i;
    end else if (own1) begin
      bus.s_we_o  = bus.m1_we_i;
      bus.s_adr_o = bus.m1_adr_i;
      bus.s_dat_o = bus.m1_dat_i;
    end

    // Master links. Grants come straight from the state register.
    // Stall is combinational from stb, so it is forced low while reset is
    // held to keep every output at 0 during reset.
    bus.m0_gnt_o   = own0;
    bus.m1_gnt_o   = own1;
    bus.m0_stall_o = reset_ni & (own0 ? (bus.m0_stb_i & cnt_full) : bus.m0_stb_i);
    bus.m1_stall_o = reset_ni & (own1 ? (bus.m1_stb_i & cnt_full) : bus.m1_stb_i);
    bus.m0_ack_o   = own0 & ack_ok;
    bus.m1_ack_o   = own1 & ack_ok;
    bus.m0_dat_o   = (own0 & ack_ok) ? bus.s_dat_i : '0;
    bus.m1_dat_o   = (own1 & ack_ok) ? bus.s_dat_i : '0;

    // Outstanding-beat counter; stb and ack together leave it unchanged.
    count_d = count_q;
    if (fwd_stb && !ack_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!fwd_stb && ack_ok) begin
      count_d = count_q - CNT_ONE;
    end

    // Owner lets go once cyc is low and nothing will be left outstanding.
    release_own = ~own_cyc & (count_d == '0);

    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (bus.m0_cyc_i) begin
          state_d = OWN0;
        end else if (bus.m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (release_own) begin
          last_d  = 1'b0;
          state_d = bus.m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (release_own) begin
          last_d  = 1'b1;
          state_d = bus.m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_wbm_arbiter.sv
module tb_wbm_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic             clk_i;
  logic             reset_ni;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;

  wbm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wbm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus),
    .state_o  (state_o),
    .count_o  (count_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
    bus.m0_adr_i = '0;   bus.m0_dat_i = '0;
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m1_adr_i = '0;   bus.m1_dat_i = '0;
    bus.s_ack_i  = 1'b0; bus.s_dat_i  = '0;
  endtask

  function automatic logic [7+ADDR_W+2*DATA_W+3*DATA_W-1:0] all_outputs();
    return {bus.m0_gnt_o, bus.m0_stall_o, bus.m0_ack_o,
            bus.m1_gnt_o, bus.m1_stall_o, bus.m1_ack_o,
            bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
            bus.s_adr_o, bus.s_dat_o, bus.m0_dat_o, bus.m1_dat_o};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7+ADDR_W+2*DATA_W+3*DATA_W-1:0] outs;
    reset_ni = 1'b0;
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1;
    bus.m0_adr_i = 64'hFFFF_0000_1234_5678; bus.m0_dat_i = 16'hA5A5;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1;
    bus.m1_adr_i = 64'h0123_4567_89AB_CDEF; bus.m1_dat_i = 16'h5A5A;
    bus.s_ack_i  = 1'b1; bus.s_dat_i  = 16'hFFFF;
    #2;
    outs = all_outputs();
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", outs);
    end
    checks++;
    if (state_o !== ST_IDLE || count_o !== '0) begin
      errors++; $display("FAIL reset_state got st=%0d cnt=%0d exp st=0 cnt=0", state_o, count_o);
    end
    step();
    reset_ni = 1'b1;
    clear_inputs();
    bus.m0_cyc_i = 1'b1;
    step();
    checks++;
    if (bus.m0_gnt_o !== 1'b1) begin
      errors++; $display("FAIL reset_pre_gnt got %b exp 1", bus.m0_gnt_o);
    end
    // Pulse reset between edges with arbitrary inputs still applied.
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1357;
    reset_ni = 1'b0;
    #1;
    outs = all_outputs();
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_pulse_outputs got %h exp 0", outs);
    end
    #1;
    reset_ni = 1'b1;
    clear_inputs();
    step();
    checks++;
    if (state_o !== ST_IDLE || bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b0) begin
      errors++; $display("FAIL reset_after got st=%0d g0=%b g1=%b exp st=0 g0=0 g1=0",
                         state_o, bus.m0_gnt_o, bus.m1_gnt_o);
    end
  endtask

  task automatic test_lsu_write();
    logic [ADDR_W-1:0] adr_v [4];
    logic [DATA_W-1:0] wdat_v [4];
    logic [DATA_W-1:0] rdat_v [4];
    adr_v  = '{64'h1122_3344_5566_778E, 64'h1122_3344_5566_778C,
               64'h1122_3344_5566_778A, 64'h1122_3344_5566_7788};
    wdat_v = '{16'h7766, 16'h5544, 16'h3322, 16'h1100};
    rdat_v = '{16'hDEAD, 16'hBEEF, 16'h0BAD, 16'hC0DE};
    bus.m1_cyc_i = 1'b1;
    #1;
    checks++;
    if (bus.m1_gnt_o !== 1'b0) begin
      errors++; $display("FAIL lsu_gnt_c0 got %b exp 0", bus.m1_gnt_o);
    end
    step();
    checks++;
    if (bus.m1_gnt_o !== 1'b1 || bus.m0_gnt_o !== 1'b0) begin
      errors++; $display("FAIL lsu_gnt_c1 got g1=%b g0=%b exp g1=1 g0=0", bus.m1_gnt_o, bus.m0_gnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1;
      bus.m1_adr_i = adr_v[i]; bus.m1_dat_i = wdat_v[i];
      #1;
      checks++;
      if (bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1 || bus.s_cyc_o !== 1'b1 ||
          bus.s_adr_o !== adr_v[i] || bus.s_dat_o !== wdat_v[i] || bus.m1_stall_o !== 1'b0) begin
        errors++; $display("FAIL lsu_beat%0d got stb=%b we=%b adr=%h dat=%h stall=%b exp stb=1 we=1 adr=%h dat=%h stall=0",
                           i, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.m1_stall_o,
                           adr_v[i], wdat_v[i]);
      end
      step();
    end
    bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
    checks++;
    if (count_o !== 4'd4) begin
      errors++; $display("FAIL lsu_count got %0d exp 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus.s_ack_i = 1'b1; bus.s_dat_i = rdat_v[i];
      #1;
      checks++;
      if (bus.m1_ack_o !== 1'b1 || bus.m1_dat_o !== rdat_v[i] || bus.m0_ack_o !== 1'b0 ||
          bus.m0_dat_o !== '0) begin
        errors++; $display("FAIL lsu_ack%0d got a1=%b d1=%h a0=%b d0=%h exp a1=1 d1=%h a0=0 d0=0",
                           i, bus.m1_ack_o, bus.m1_dat_o, bus.m0_ack_o, bus.m0_dat_o, rdat_v[i]);
      end
      step();
    end
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    checks++;
    if (count_o !== '0 || state_o !== ST_OWN1) begin
      errors++; $display("FAIL lsu_drained got st=%0d cnt=%0d exp st=2 cnt=0", state_o, count_o);
    end
    bus.m1_cyc_i = 1'b0;
    step();
    checks++;
    if (state_o !== ST_IDLE || bus.m1_gnt_o !== 1'b0 || bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL lsu_release got st=%0d g1=%b cyc=%b exp st=0 g1=0 cyc=0",
                         state_o, bus.m1_gnt_o, bus.s_cyc_o);
    end
  endtask

  task automatic test_tie();
    // last = port 1 here, so port 0 wins the tie.
    bus.m0_cyc_i = 1'b1;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 64'h0000_0000_0000_0B0B;
    step();
    checks++;
    if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0 || bus.m1_stall_o !== 1'b1 ||
        bus.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL tie_first got g0=%b g1=%b st1=%b sstb=%b exp g0=1 g1=0 st1=1 sstb=0",
                         bus.m0_gnt_o, bus.m1_gnt_o, bus.m1_stall_o, bus.s_stb_o);
    end
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 64'h0000_0000_0000_00A0;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 64'h0000_0000_0000_00A0 || bus.m1_stall_o !== 1'b1) begin
      errors++; $display("FAIL tie_m0_beat got sstb=%b adr=%h st1=%b exp sstb=1 adr=a0 st1=1",
                         bus.s_stb_o, bus.s_adr_o, bus.m1_stall_o);
    end
    step();
    bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1234;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 16'h1234 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL tie_m0_ack got a0=%b d0=%h a1=%b exp a0=1 d0=1234 a1=0",
                         bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o);
    end
    step();
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    bus.m0_cyc_i = 1'b0;
    step();
    // Direct hand-off: no IDLE cycle in between.
    checks++;
    if (state_o !== ST_OWN1 || bus.m1_gnt_o !== 1'b1 || bus.m0_gnt_o !== 1'b0) begin
      errors++; $display("FAIL tie_handoff got st=%0d g1=%b g0=%b exp st=2 g1=1 g0=0",
                         state_o, bus.m1_gnt_o, bus.m0_gnt_o);
    end
    checks++;
    if (bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 64'h0000_0000_0000_0B0B || bus.m1_stall_o !== 1'b0) begin
      errors++; $display("FAIL tie_m1_beat got sstb=%b adr=%h st1=%b exp sstb=1 adr=b0b st1=0",
                         bus.s_stb_o, bus.s_adr_o, bus.m1_stall_o);
    end
    step();
    bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b1;
    step();
    bus.s_ack_i = 1'b0; bus.m1_cyc_i = 1'b0;
    step();
    // m1 was last: the next tie goes to m0.
    bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
    step();
    checks++;
    if (state_o !== ST_OWN0) begin
      errors++; $display("FAIL tie_second got st=%0d exp st=1", state_o);
    end
    bus.m0_cyc_i = 1'b0; bus.m1_cyc_i = 1'b0;
    step();
    // m0 was last: the next tie goes to m1.
    bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
    step();
    checks++;
    if (state_o !== ST_OWN1) begin
      errors++; $display("FAIL tie_third got st=%0d exp st=2", state_o);
    end
    bus.m0_cyc_i = 1'b0; bus.m1_cyc_i = 1'b0;
    step();
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL tie_end got st=%0d exp st=0", state_o);
    end
  endtask

  task automatic test_drain();
    bus.m0_cyc_i = 1'b1;
    step();
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 64'h0000_0000_0000_1000;
    step();
    bus.m0_adr_i = 64'h0000_0000_0000_1002;
    step();
    bus.m0_stb_i = 1'b0; bus.m0_cyc_i = 1'b0; bus.m1_cyc_i = 1'b1;
    #1;
    checks++;
    if (count_o !== 4'd2 || bus.m0_gnt_o !== 1'b1) begin
      errors++; $display("FAIL drain_start got cnt=%0d g0=%b exp cnt=2 g0=1", count_o, bus.m0_gnt_o);
    end
    step();
    checks++;
    if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin
      errors++; $display("FAIL drain_hold got g0=%b g1=%b exp g0=1 g1=0", bus.m0_gnt_o, bus.m1_gnt_o);
    end
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hAAAA;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 16'hAAAA) begin
      errors++; $display("FAIL drain_ack1 got a0=%b d0=%h exp a0=1 d0=aaaa", bus.m0_ack_o, bus.m0_dat_o);
    end
    step();
    checks++;
    if (count_o !== 4'd1 || bus.m0_gnt_o !== 1'b1) begin
      errors++; $display("FAIL drain_mid got cnt=%0d g0=%b exp cnt=1 g0=1", count_o, bus.m0_gnt_o);
    end
    bus.s_dat_i = 16'h5555;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 16'h5555 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL drain_ack2 got a0=%b d0=%h a1=%b exp a0=1 d0=5555 a1=0",
                         bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o);
    end
    step();
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    checks++;
    if (bus.m1_gnt_o !== 1'b1 || bus.m0_gnt_o !== 1'b0 || count_o !== '0) begin
      errors++; $display("FAIL drain_handoff got g1=%b g0=%b cnt=%0d exp g1=1 g0=0 cnt=0",
                         bus.m1_gnt_o, bus.m0_gnt_o, count_o);
    end
    bus.m1_cyc_i = 1'b0;
    step();
  endtask

  task automatic test_counter_edges();
    bus.m1_cyc_i = 1'b1;
    step();
    // Spurious ack with nothing outstanding.
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hEEEE;
    #1;
    checks++;
    if (bus.m1_ack_o !== 1'b0 || bus.m1_dat_o !== '0 || bus.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL spurious_ack got a1=%b d1=%h a0=%b exp a1=0 d1=0 a0=0",
                         bus.m1_ack_o, bus.m1_dat_o, bus.m0_ack_o);
    end
    step();
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    checks++;
    if (count_o !== '0) begin
      errors++; $display("FAIL spurious_count got %0d exp 0", count_o);
    end
    bus.m1_stb_i = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (count_o !== 4'd15 || bus.s_stb_o !== 1'b0 || bus.m1_stall_o !== 1'b1) begin
      errors++; $display("FAIL full_block got cnt=%0d sstb=%b st1=%b exp cnt=15 sstb=0 st1=1",
                         count_o, bus.s_stb_o, bus.m1_stall_o);
    end
    step();
    checks++;
    if (count_o !== 4'd15 || bus.m1_stall_o !== 1'b1) begin
      errors++; $display("FAIL full_hold got cnt=%0d st1=%b exp cnt=15 st1=1", count_o, bus.m1_stall_o);
    end
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.m1_ack_o !== 1'b1 || bus.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL full_ack got a1=%b sstb=%b exp a1=1 sstb=0", bus.m1_ack_o, bus.s_stb_o);
    end
    step();
    checks++;
    if (count_o !== 4'd14 || bus.s_stb_o !== 1'b1 || bus.m1_stall_o !== 1'b0) begin
      errors++; $display("FAIL unstall got cnt=%0d sstb=%b st1=%b exp cnt=14 sstb=1 st1=0",
                         count_o, bus.s_stb_o, bus.m1_stall_o);
    end
    // Beat and ack together leave the count alone.
    step();
    checks++;
    if (count_o !== 4'd14) begin
      errors++; $display("FAIL stb_and_ack got cnt=%0d exp 14", count_o);
    end
    bus.m1_stb_i = 1'b0;
    for (int i = 0; i < 14; i++) step();
    bus.s_ack_i = 1'b0;
    checks++;
    if (count_o !== '0) begin
      errors++; $display("FAIL counter_drain got cnt=%0d exp 0", count_o);
    end
    bus.m1_cyc_i = 1'b0;
    step();
  endtask

  task automatic test_async_reset_mid();
    bus.m1_cyc_i = 1'b1;
    step();
    bus.m1_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (count_o !== 4'd3 || state_o !== ST_OWN1 || bus.s_stb_o !== 1'b1) begin
      errors++; $display("FAIL midburst_setup got cnt=%0d st=%0d sstb=%b exp cnt=3 st=2 sstb=1",
                         count_o, state_o, bus.s_stb_o);
    end
    reset_ni = 1'b0;
    #1;
    checks++;
    if (bus.m1_gnt_o !== 1'b0 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 ||
        bus.m1_stall_o !== 1'b0 || count_o !== '0 || state_o !== ST_IDLE) begin
      errors++; $display("FAIL midburst_reset got g1=%b cyc=%b sstb=%b st1=%b cnt=%0d st=%0d exp all 0",
                         bus.m1_gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m1_stall_o, count_o, state_o);
    end
    #1;
    reset_ni = 1'b1;
    clear_inputs();
    bus.m0_cyc_i = 1'b1;
    step();
    checks++;
    if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0 || count_o !== '0) begin
      errors++; $display("FAIL midburst_regrant got g0=%b g1=%b cnt=%0d exp g0=1 g1=0 cnt=0",
                         bus.m0_gnt_o, bus.m1_gnt_o, count_o);
    end
    bus.m0_cyc_i = 1'b0;
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_lsu_write();
    test_tie();
    test_drain();
    test_counter_edges();
    test_async_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
